pico_ctrl: RTL
==============

Name: pico_ctrl

Overview:
- Multi-cycle control unit for the pico-MIPS core.
- Fetches an instruction and decodes it into an instruction register.
- Drives the ALU function code, register-file and PC control strobes, and the immediate/input operand selects.
- Sequences a press/release handshake with the user push-button for the IN instruction.
- Sits between instruction memory, PC, register file and the N-bit ALU.

Parameters:
- IW, 20, instruction width. Fixed layout: op[19:16], rd[15:13], rs[12:10], imm[7:0]; bits [9:8] ignored.
- RW, 3, register address width.
- N, 8, immediate/data width; matches ALU N.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr  input  IW  instruction at current PC; valid combinationally during FETCH.
- zf  input  1  ALU zero flag for the current cycle.
- btn  input  1  user push-button, already synchronised, active-high.
- alu_func  output  3  ALU function code, using alucodes.sv names: RA, RB, RADD, RSUB, RAND, ROR, RXOR, RMUL.
- rd_addr  output  RW  ir.rd; also used as ALU operand-A read address.
- rs_addr  output  RW  ir.rs; operand-B read address.
- imm  output  N  ir.imm.
- imm_sel  output  1  1 = ALU operand B is imm, 0 = register rs.
- in_sel  output  1  1 = register write data comes from switches, 0 = ALU result.
- reg_we  output  1  register-file write enable for rd, single cycle.
- pc_inc  output  1  PC <= PC+1 at the next edge.
- pc_load  output  1  PC <= imm at the next edge. Never asserted together with pc_inc.
- out_we  output  1  latch ALU result into the output (LED) register.
- halted  output  1  high while in HALT.

Behaviour:
- State machine: FETCH, EXEC, WAIT_PRESS, WAIT_RELEASE, HALT.
- Reset (asynchronous, any state, mid-handshake included): state = FETCH, ir = 0 (NOP). While reset is held, all strobes are 0, alu_func = RA and halted = 0.
- All outputs are combinational from state and ir. Strobes are 0 in FETCH, HALT and WAIT_RELEASE, except the pc_inc on release noted below.
- FETCH: ir <= instr, then go to EXEC. Normal instructions take 2 cycles.
- EXEC, decoded by op (every path asserts exactly one PC strobe unless noted):
  - 0 NOP: pc_inc.
  - 1 ADD: func RADD, imm_sel 0, reg_we, pc_inc.
  - 2 ADDI: func RADD, imm_sel 1, reg_we, pc_inc.
  - 3 SUB / 4 SUBI: func RSUB, imm_sel 0 / 1 respectively, reg_we, pc_inc.
  - 5 MUL / 6 MULI: func RMUL, imm_sel 0 / 1 respectively, reg_we, pc_inc. Result is the signed high half, per ALU.
  - 7 AND, 8 OR, 9 XOR: func RAND / ROR / RXOR, imm_sel 0, reg_we, pc_inc.
  - A BEQ: func RSUB, imm_sel 0, no reg_we. zf=1 gives pc_load, else pc_inc.
  - B BNE: as BEQ with the zf sense inverted.
  - C J: pc_load.
  - D IN: no strobes; go to WAIT_PRESS.
  - E OUT: func RA, out_we, pc_inc.
  - F HALT: no strobes; go to HALT.
  - All ops except D and F return to FETCH.
- WAIT_PRESS: while btn=0, stay with no strobes. When btn=1, assert reg_we and in_sel for one cycle, then go to WAIT_RELEASE.
- WAIT_RELEASE: while btn=1, stay with no strobes. When btn=0, assert pc_inc and go to FETCH.
  - A button already held when IN executes is accepted in the first WAIT_PRESS cycle.
  - A held button therefore causes exactly one write per IN, never repeated writes.
- HALT: stays there until reset; halted = 1, all strobes 0.
- Writes to rd = 0 are not special in this block; register-file policy applies.
- zf is sampled only in EXEC of BEQ/BNE. Branch target is absolute (imm); it wraps naturally in the PC width.

Test Plan:
- Reset then ADDI r1,r0,5 (instr 0x22005): FETCH 1 cycle, then EXEC with alu_func=RADD, imm_sel=1, reg_we=1, pc_inc=1, rd_addr=1, imm=0x05. Back in FETCH on the 3rd cycle.
- BEQ with zf=1, imm=0x10: EXEC shows pc_load=1, pc_inc=0, reg_we=0. Repeat with zf=0: pc_inc=1, pc_load=0. BNE gives the inverse in both cases.
- IN with btn held low 5 cycles, then high 3 cycles, then low: exactly one reg_we+in_sel pulse, in the first btn-high cycle. pc_inc pulses once, in the first btn-low cycle after release. Next FETCH follows.
- IN with btn already high at EXEC: write occurs in the first WAIT_PRESS cycle. No second write while btn stays high.
- HALT (op F): halted=1 indefinitely with all strobes 0 and instr/btn toggling ignored. Reset asserted asynchronously gives halted=0 and state FETCH without a clock edge.
- Reset asserted in WAIT_RELEASE: no pc_inc or reg_we pulse. After release the FETCH/EXEC sequence restarts with ir=NOP semantics until the first fetch.

Source files
------------

// File: rtl/pico_ctrl.sv
// Multi-cycle control unit for the pico-MIPS core: fetches into an instruction
// register, decodes it, and sequences the push-button handshake for IN.
module pico_ctrl #(
   parameter int IW = 20,
   parameter int RW = 3,
   parameter int N  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] instr,
   input  logic          zf,
   input  logic          btn,
   output logic [2:0]    alu_func,
   output logic [RW-1:0] rd_addr,
   output logic [RW-1:0] rs_addr,
   output logic [N-1:0]  imm,
   output logic          imm_sel,
   output logic          in_sel,
   output logic          reg_we,
   output logic          pc_inc,
   output logic          pc_load,
   output logic          out_we,
   output logic          halted,
   output logic [2:0]    state_dbg
);

   localparam logic [2:0] RA   = 3'd0;
   localparam logic [2:0] RB   = 3'd1;
   localparam logic [2:0] RADD = 3'd2;
   localparam logic [2:0] RSUB = 3'd3;
   localparam logic [2:0] RAND = 3'd4;
   localparam logic [2:0] ROR  = 3'd5;
   localparam logic [2:0] RXOR = 3'd6;
   localparam logic [2:0] RMUL = 3'd7;

   typedef enum logic [2:0] {
      S_FETCH        = 3'd0,
      S_EXEC         = 3'd1,
      S_WAIT_PRESS   = 3'd2,
      S_WAIT_RELEASE = 3'd3,
      S_HALT         = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    op_q, op_d;
   logic [RW-1:0] rd_q, rd_d;
   logic [RW-1:0] rs_q, rs_d;
   logic [N-1:0]  imm_q, imm_d;

   // Bits [9:8] of the instruction carry no meaning; RB is never issued here.
   logic unused_bits;
   assign unused_bits = ^{instr[9:8], RB};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         rd_q    <= '0;
         rs_q    <= '0;
         imm_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         rs_q    <= rs_d;
         imm_q   <= imm_d;
      end
   end

   assign rd_addr   = rd_q;
   assign rs_addr   = rs_q;
   assign imm       = imm_q;
   assign state_dbg = state_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rs_d     = rs_q;
      imm_d    = imm_q;
      alu_func = RA;
      imm_sel  = 1'b0;
      in_sel   = 1'b0;
      reg_we   = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      out_we   = 1'b0;
      halted   = 1'b0;
      case (state_q)
         S_FETCH: begin
            op_d    = instr[19:16];
            rd_d    = instr[15:13];
            rs_d    = instr[12:10];
            imm_d   = instr[7:0];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op_q)
               4'h0: pc_inc = 1'b1;
               4'h1, 4'h2: begin
                  alu_func = RADD;
                  imm_sel  = (op_q == 4'h2);
                  reg_we   = 1'b1;
                  pc_inc   = 1'b1;
               end
               4'h3, 4'h4: begin
                  alu_func = RSUB;
                  imm_sel  = (op_q == 4'h4);
                  reg_we   = 1'b1;
                  pc_inc   = 1'b1;
               end
               4'h5, 4'h6: begin
                  alu_func = RMUL;
                  imm_sel  = (op_q == 4'h6);
                  reg_we   = 1'b1;
                  pc_inc   = 1'b1;
               end
               4'h7, 4'h8, 4'h9: begin
                  alu_func = (op_q == 4'h7) ? RAND : (op_q == 4'h8) ? ROR : RXOR;
                  reg_we   = 1'b1;
                  pc_inc   = 1'b1;
               end
               // Branches compare rd and rs through the ALU; BNE flips the zf sense.
               4'hA, 4'hB: begin
                  alu_func = RSUB;
                  if (zf ^ (op_q == 4'hB)) pc_load = 1'b1;
                  else                     pc_inc  = 1'b1;
               end
               4'hC: pc_load = 1'b1;
               4'hD: state_d = S_WAIT_PRESS;
               4'hE: begin
                  out_we = 1'b1;
                  pc_inc = 1'b1;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_WAIT_PRESS: begin
            if (btn) begin
               reg_we  = 1'b1;
               in_sel  = 1'b1;
               state_d = S_WAIT_RELEASE;
            end
         end
         S_WAIT_RELEASE: begin
            if (!btn) begin
               pc_inc  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

endmodule
